dmux4way16_stream: RTL

Streaming 4-way demultiplexer for 16-bit words. It routes each word from one valid/ready input stream to one of four output channels, selected per word by a 2-bit channel select. Each output channel has a one-entry holding register. It is the write-side counterpart of Mux4Way16, and feeds four independent 16-bit consumers from a single producer.

---
 rtl/dmux4way16_pkg.sv | 20 ++
 rtl/dmux4way16_slot.sv | 33 +++
 rtl/dmux4way16_stream.sv | 60 ++++++
 3 files changed

// File: rtl/dmux4way16_pkg.sv
// Shared types and sizes for the 4-way 16-bit stream demultiplexer.
// Channel slots are one-entry holding registers encoded EMPTY/FULL.
package dmux4way16_pkg;
   localparam int DMUX_WIDTH    = 16;
   localparam int DMUX_CHANNELS = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

   function automatic logic [DMUX_CHANNELS-1:0] sel_onehot(input sel_t sel);
      logic [DMUX_CHANNELS-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction
endpackage

// File: rtl/dmux4way16_slot.sv
// One-entry output holding register: load wins over take, so load+take keeps it FULL.
// Latency: loaded word is visible after the loading edge; data holds its last value when emptied.
module dmux4way16_slot
   import dmux4way16_pkg::*;
#(
   parameter int WIDTH = DMUX_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             ready,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             valid
);

   slot_state_e state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         dout  <= '0;
      end else if (load) begin
         state <= FULL;
         dout  <= din;
      end else if (valid && ready) begin
         state <= EMPTY;
      end
   end

   assign valid = (state == FULL);

endmodule

// File: rtl/dmux4way16_stream.sv
// Routes each input word to one of four one-entry output channels (latency 1, 1 word/cycle);
// in_ready only reflects the selected channel; DMUX4WAY16_BROADCAST_EN adds in_bcast to load all four.
module dmux4way16_stream
   import dmux4way16_pkg::*;
#(
   parameter int WIDTH = DMUX_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         in_data,
   input  sel_t                     in_sel,
   input  logic                     in_valid,
`ifdef DMUX4WAY16_BROADCAST_EN
   input  logic                     in_bcast,
`endif
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data0,
   output logic [WIDTH-1:0]         out_data1,
   output logic [WIDTH-1:0]         out_data2,
   output logic [WIDTH-1:0]         out_data3,
   output logic [DMUX_CHANNELS-1:0] out_valid,
   input  logic [DMUX_CHANNELS-1:0] out_ready
);

   logic [DMUX_CHANNELS-1:0] slot_free;
   logic [DMUX_CHANNELS-1:0] tgt;
   logic [DMUX_CHANNELS-1:0] load;
   logic [WIDTH-1:0]         slot_data [DMUX_CHANNELS];

   // A slot can accept when it is empty or is being drained this same cycle.
   assign slot_free = ~out_valid | out_ready;

`ifdef DMUX4WAY16_BROADCAST_EN
   assign tgt      = in_bcast ? {DMUX_CHANNELS{1'b1}} : sel_onehot(in_sel);
   assign in_ready = in_bcast ? &slot_free : slot_free[in_sel];
`else
   assign tgt      = sel_onehot(in_sel);
   assign in_ready = slot_free[in_sel];
`endif

   assign load = tgt & {DMUX_CHANNELS{in_valid & in_ready}};

   for (genvar k = 0; k < DMUX_CHANNELS; k++) begin : g_slot
      dmux4way16_slot #(.WIDTH(WIDTH)) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load[k]),
         .ready (out_ready[k]),
         .din   (in_data),
         .dout  (slot_data[k]),
         .valid (out_valid[k])
      );
   end

   assign out_data0 = slot_data[0];
   assign out_data1 = slot_data[1];
   assign out_data2 = slot_data[2];
   assign out_data3 = slot_data[3];

endmodule
